// File: rtl/multicycle_ctrl.sv
// Control unit for the multicycle ARM-subset core: phase FSM, ALU decode, NZCV flags and condition gating.
// Optional CMP/NoWrite decoding is enabled by defining CTRL_NOWRITE_EN.
module multicycle_ctrl #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic [3:0] dbg_state_o,
    output logic [3:0] dbg_flags_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    // Raw (ungated) per-state controls.
    logic       next_pc, branch, reg_w, mem_w, alu_op, ir_write_raw;
    logic [1:0] flag_w;
    logic       no_write;
    logic       cond_ex;
    logic       pcs;
    logic       fl_n, fl_z, fl_c, fl_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= FLAG_RESET;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        next_pc      = 1'b0;
        branch       = 1'b0;
        reg_w        = 1'b0;
        mem_w        = 1'b0;
        alu_op       = 1'b0;
        ir_write_raw = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                next_pc      = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB:  reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
`ifdef CTRL_NOWRITE_EN
                4'b1010: ALUControl = 2'b01;
`endif
                default: ALUControl = 2'b00;
            endcase
            flag_w[1] = Funct[0];
            flag_w[0] = Funct[0] & ~ALUControl[1];
        end
    end

    // NoWrite must hold through ALUWB, where ALUOp is already 0, so it decodes from Funct alone.
`ifdef CTRL_NOWRITE_EN
    assign no_write = (Op == 2'b00) && (Funct[4:1] == 4'b1010);
`else
    assign no_write = 1'b0;
`endif

    assign {fl_n, fl_z, fl_c, fl_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = fl_z;
            4'b0001: cond_ex = ~fl_z;
            4'b0010: cond_ex = fl_c;
            4'b0011: cond_ex = ~fl_c;
            4'b0100: cond_ex = fl_n;
            4'b0101: cond_ex = ~fl_n;
            4'b0110: cond_ex = fl_v;
            4'b0111: cond_ex = ~fl_v;
            4'b1000: cond_ex = fl_c & ~fl_z;
            4'b1001: cond_ex = ~fl_c | fl_z;
            4'b1010: cond_ex = ~(fl_n ^ fl_v);
            4'b1011: cond_ex = fl_n ^ fl_v;
            4'b1100: cond_ex = ~fl_z & ~(fl_n ^ fl_v);
            4'b1101: cond_ex = fl_z | (fl_n ^ fl_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (flag_w[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end

    // Architectural writes are squashed combinationally while reset is high.
    assign pcs      = branch | (reg_w & (Rd == 4'hF));
    assign PCWrite  = (next_pc | (pcs & cond_ex)) & ~reset;
    assign RegWrite = reg_w & cond_ex & ~no_write & ~reset;
    assign MemWrite = mem_w & cond_ex & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};

    assign dbg_state_o = state_q;
    assign dbg_flags_o = flags_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level cycle model, per-cycle compare, directed and random instructions.
module tb_multicycle_ctrl;
  localparam logic [3:0] FLAG_RST = 4'b0110;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] dbg_state, dbg_flags;

  multicycle_ctrl #(.FLAG_RESET(FLAG_RST)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .dbg_state_o(dbg_state), .dbg_flags_o(dbg_flags)
  );

  always #5 clk = ~clk;

  // Vector: pcw[19] adr[18] memw[17] irw[16] rs[15:14] aluc[13:12] srca[11] srcb[10:9] regw[8] imm[7:6] regsrc[5:4] flags[3:0]
  logic [19:0] act_vec;
  assign act_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA,
                    ALUSrcB, RegWrite, ImmSrc, RegSrc, dbg_flags};

  logic [19:0] exp_q[$];
  logic [19:0] snap [5];
  logic [3:0]  mf;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_cmp(input logic [5:0] f);
`ifdef CTRL_NOWRITE_EN
    return f[4:1] == 4'b1010;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] alu_of(input logic [5:0] f);
    if (is_cmp(f)) return 2'b01;
    case (f[4:1])
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [19:0] a, input logic [19:0] x);
    n_cmp++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, a, x);
    end
  endtask

  // Entered at posedge+1 of the cycle that must be FETCH; returns at posedge+1 after the last cycle.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] xf, input int ncyc);
    int len;
    logic [1:0] alu, fw;
    logic nw, ce;
    logic [19:0] e;
    case (o)
      2'b00: len = 4;
      2'b01: len = f[0] ? 5 : 4;
      2'b10: len = 3;
      default: len = 2;
    endcase
    if (ncyc > 0 && ncyc < len) len = ncyc;
    alu = alu_of(f);
    nw  = (o == 2'b00) && is_cmp(f);
    fw  = {f[0], f[0] && (alu == 2'b00 || alu == 2'b01)};
    for (int k = 0; k < len; k++) begin
      Cond = c; Op = o; Funct = f; Rd = r;
      ALUFlags = 4'($urandom_range(0, 15));
      ce = cond_holds(c, mf);
      e = '0;
      e[7:6] = o;
      e[5:4] = {o == 2'b01, o == 2'b10};
      e[3:0] = mf;
      if (k == 0) begin
        e[19] = 1'b1; e[16] = 1'b1; e[15:14] = 2'b10; e[11] = 1'b1; e[10:9] = 2'b10;
      end else if (k == 1) begin
        e[15:14] = 2'b10; e[11] = 1'b1; e[10:9] = 2'b10;
      end else begin
        case (o)
          2'b00: if (k == 2) begin
                   e[13:12] = alu; e[10:9] = f[5] ? 2'b01 : 2'b00; ALUFlags = xf;
                 end else begin
                   e[8] = ce && !nw; e[19] = ce && (r == 4'hF);
                 end
          2'b01: if (k == 2) e[10:9] = 2'b01;
                 else if (k == 3) begin e[18] = 1'b1; e[17] = ce && !f[0]; end
                 else begin e[15:14] = 2'b01; e[8] = ce; e[19] = ce && (r == 4'hF); end
          2'b10: begin e[10:9] = 2'b01; e[15:14] = 2'b10; e[19] = ce; end
          default: ;
        endcase
      end
      exp_q.push_back(e);
      #3 snap[k] = act_vec;
      if (o == 2'b00 && k == 2 && ce) begin
        if (fw[1]) mf[3:2] = xf[3:2];
        if (fw[0]) mf[1:0] = xf[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) check($sformatf("ctrl_cyc%0d", cyc), act_vec, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mf = FLAG_RST;
    #12;
    check("reset_outputs", act_vec, {12'b0000_10_00_1_10_0, 4'b0000, FLAG_RST});
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0, 0);          // ADD imm
    check("addi_aluc", 20'(snap[2][13:12]), 20'd0);
    check("addi_srcb", 20'(snap[2][10:9]), 20'd1);
    check("addi_regw_exec", 20'(snap[2][8]), 20'd0);
    check("addi_regw_wb", 20'(snap[3][8]), 20'd1);

    run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 0);       // SUBS reg
    check("subs_flags", 20'(snap[3][3:0]), 20'b0100);
    run_instr(4'h0, 2'b00, 6'b101000, 4'h3, 4'h0, 0);          // ADDEQ
    check("addeq_regw", 20'(snap[3][8]), 20'd1);
    run_instr(4'h1, 2'b00, 6'b101000, 4'h3, 4'h0, 0);          // ADDNE
    check("addne_regw", 20'(snap[3][8]), 20'd0);

    run_instr(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0, 0);          // LDR
    check("ldr_adrsrc", 20'(snap[3][18]), 20'd1);
    check("ldr_rs_wb", 20'(snap[4][15:14]), 20'd1);
    check("ldr_regw_wb", 20'(snap[4][8]), 20'd1);
    run_instr(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 0);          // STR
    check("str_memw_adr", 20'(snap[2][17]), 20'd0);
    check("str_memw_wr", 20'(snap[3][17]), 20'd1);

    run_instr(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 0);          // B
    check("b_pcw_fetch", 20'(snap[0][19]), 20'd1);
    check("b_pcw_decode", 20'(snap[1][19]), 20'd0);
    check("b_pcw_branch", 20'(snap[2][19]), 20'd1);
    run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0000, 0);       // SUBS clears Z
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 0);          // BEQ not taken
    check("beq_pcw_fetch", 20'(snap[0][19]), 20'd1);
    check("beq_pcw_branch", 20'(snap[2][19]), 20'd0);

    run_instr(4'hE, 2'b00, 6'b101000, 4'hF, 4'h0, 0);          // ADD to PC
    check("addpc_pcw", 20'(snap[3][19]), 20'd1);
    check("addpc_regw", 20'(snap[3][8]), 20'd1);

    run_instr(4'hE, 2'b00, 6'b110101, 4'h5, 4'b0100, 0);       // CMP encoding
    check("cmp_flags", 20'(snap[3][3:0]), 20'b0100);
`ifdef CTRL_NOWRITE_EN
    check("cmp_regw", 20'(snap[3][8]), 20'd0);
`else
    check("cmp_regw", 20'(snap[3][8]), 20'd1);
`endif

    run_instr(4'hE, 2'b01, 6'b011000, 4'h6, 4'h0, 3);          // STR up to MEMWR
    #2;
    check("mid_memw_before", 20'(MemWrite), 20'd1);
    reset = 1'b1;
    #1;
    check("mid_memw_reset", 20'(MemWrite), 20'd0);
    check("mid_reset_outputs", act_vec, {12'b0000_10_00_1_10_0, 2'b01, 2'b10, FLAG_RST});
    mf = FLAG_RST;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      run_instr(c, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
    end

    @(negedge clk);
    check("queue_drained", 20'(exp_q.size()), 20'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
